// File: rtl/bcom_mode_engine.sv
// -----------------------------------------------------------------------------
// bcom_mode_engine
// Block-cipher operation-mode engine (ECB, CBC, OFB, CTR, full-block CFB)
// wrapped around an external single-block cipher core. Accepts one block over
// a valid/ready input stream, runs one core operation per block, applies
// chaining/XOR and returns the result over a valid/ready output stream.
//
// Parameters:
//   BLOCK_W  block and IV width in bits
//   CTR_W    width of the CTR increment field (low bits of the chain register)
//
// Ports:
//   Clk, RstN            clock, asynchronous active-low reset
//   clr                  synchronous soft clear (highest priority)
//   mode, encrypt        0 ECB, 1 CBC, 2 OFB, 3 CTR, 4 CFB; 5-7 reserved
//   iv_load, iv          load chain register (honoured in IDLE only)
//   in_valid/in_ready/in_data      input block stream
//   out_valid/out_ready/out_data   result stream
//   mode_err             reserved mode selected (combinational)
//   busy                 engine not idle
//   core_start/core_enc/core_din   core launch interface
//   core_done/core_dout            core result interface
//   blk_cnt              completed-block counter (only with BCOM_BLKCNT_EN)
//
// Build option: define BCOM_BLKCNT_EN to add the saturating blk_cnt output.
// -----------------------------------------------------------------------------
module bcom_mode_engine #(
  parameter int BLOCK_W = 128,
  parameter int CTR_W   = 32
) (
  input  logic               Clk,
  input  logic               RstN,
  input  logic               clr,
  input  logic [2:0]         mode,
  input  logic               encrypt,
  input  logic               iv_load,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic               mode_err,
  output logic               busy,
`ifdef BCOM_BLKCNT_EN
  output logic [31:0]        blk_cnt,
`endif
  output logic               core_start,
  output logic               core_enc,
  output logic [BLOCK_W-1:0] core_din,
  input  logic               core_done,
  input  logic [BLOCK_W-1:0] core_dout
);

  localparam logic [2:0] M_ECB = 3'd0;
  localparam logic [2:0] M_CBC = 3'd1;
  localparam logic [2:0] M_OFB = 3'd2;
  localparam logic [2:0] M_CTR = 3'd3;
  localparam logic [2:0] M_CFB = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUT    = 2'd3
  } state_t;

  state_t             state_r;
  logic [BLOCK_W-1:0] chain_r;
  logic [BLOCK_W-1:0] data_r;
  logic [2:0]         mode_r;
  logic               enc_r;
  logic               out_valid_r;
  logic [BLOCK_W-1:0] out_data_r;
  logic               core_start_r;
  logic               core_enc_r;
  logic [BLOCK_W-1:0] core_din_r;

  logic               mode_err_s;
  logic               in_ready_s;
  logic               accept_s;
  logic [BLOCK_W-1:0] launch_din_s;
  logic               launch_enc_s;
  logic [BLOCK_W-1:0] ctr_next_s;
  logic [BLOCK_W-1:0] res_out_s;
  logic [BLOCK_W-1:0] res_chain_s;

  // Reserved-mode detect and input handshake; iv_load steals the accept slot
  always_comb begin
    mode_err_s = (mode > M_CFB);
    in_ready_s = (state_r == ST_IDLE) && !iv_load && !mode_err_s;
    accept_s   = in_valid && in_ready_s;
  end

  // Core operand chosen from the live inputs, registered on the accept edge
  always_comb begin
    launch_din_s = in_data;
    launch_enc_s = 1'b1;
    case (mode)
      M_ECB: begin
        launch_din_s = in_data;
        launch_enc_s = encrypt;
      end
      M_CBC: begin
        if (encrypt) begin
          launch_din_s = in_data ^ chain_r;
          launch_enc_s = 1'b1;
        end else begin
          launch_din_s = in_data;
          launch_enc_s = 1'b0;
        end
      end
      M_OFB, M_CTR, M_CFB: begin
        // Stream modes always run the core forward on the chain register
        launch_din_s = chain_r;
        launch_enc_s = 1'b1;
      end
      default: begin
        launch_din_s = in_data;
        launch_enc_s = 1'b1;
      end
    endcase
  end

  // CTR step: only the low CTR_W bits count, upper bits are left untouched
  always_comb begin
    ctr_next_s              = chain_r;
    ctr_next_s[CTR_W-1:0]   = chain_r[CTR_W-1:0] + CTR_W'(1'b1);
  end

  // Result and next chain value from the latched block and core output
  always_comb begin
    res_out_s   = core_dout ^ data_r;
    res_chain_s = chain_r;
    case (mode_r)
      M_ECB: begin
        res_out_s   = core_dout;
        res_chain_s = chain_r;
      end
      M_CBC: begin
        if (enc_r) begin
          res_out_s   = core_dout;
          res_chain_s = core_dout;
        end else begin
          res_out_s   = core_dout ^ chain_r;
          res_chain_s = data_r;
        end
      end
      M_OFB: begin
        res_out_s   = core_dout ^ data_r;
        res_chain_s = core_dout;
      end
      M_CTR: begin
        res_out_s   = core_dout ^ data_r;
        res_chain_s = ctr_next_s;
      end
      M_CFB: begin
        // Feedback is always the ciphertext: our output on encrypt, input on decrypt
        res_out_s = core_dout ^ data_r;
        if (enc_r) begin
          res_chain_s = core_dout ^ data_r;
        end else begin
          res_chain_s = data_r;
        end
      end
      default: begin
        res_out_s   = core_dout ^ data_r;
        res_chain_s = chain_r;
      end
    endcase
  end

  // Sequencer FSM with all outputs registered; clr mirrors reset
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      state_r      <= ST_IDLE;
      chain_r      <= {BLOCK_W{1'b0}};
      data_r       <= {BLOCK_W{1'b0}};
      mode_r       <= 3'd0;
      enc_r        <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {BLOCK_W{1'b0}};
      core_start_r <= 1'b0;
      core_enc_r   <= 1'b0;
      core_din_r   <= {BLOCK_W{1'b0}};
    end else if (clr) begin
      state_r      <= ST_IDLE;
      chain_r      <= {BLOCK_W{1'b0}};
      data_r       <= {BLOCK_W{1'b0}};
      mode_r       <= 3'd0;
      enc_r        <= 1'b0;
      out_valid_r  <= 1'b0;
      out_data_r   <= {BLOCK_W{1'b0}};
      core_start_r <= 1'b0;
      core_enc_r   <= 1'b0;
      core_din_r   <= {BLOCK_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          core_start_r <= 1'b0;
          if (iv_load) begin
            chain_r <= iv;
          end else if (accept_s) begin
            data_r       <= in_data;
            mode_r       <= mode;
            enc_r        <= encrypt;
            core_din_r   <= launch_din_s;
            core_enc_r   <= launch_enc_s;
            core_start_r <= 1'b1;
            state_r      <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // core_din/core_enc stay put until the result is captured
          core_start_r <= 1'b0;
          state_r      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (core_done) begin
            out_data_r  <= res_out_s;
            chain_r     <= res_chain_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          out_valid_r  <= 1'b0;
          core_start_r <= 1'b0;
        end
      endcase
    end
  end

`ifdef BCOM_BLKCNT_EN
  logic [31:0] blk_cnt_r;

  // Saturating count of delivered blocks; restarts with every new IV
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      blk_cnt_r <= 32'd0;
    end else if (clr) begin
      blk_cnt_r <= 32'd0;
    end else if (iv_load && (state_r == ST_IDLE)) begin
      blk_cnt_r <= 32'd0;
    end else if (out_valid_r && out_ready && (blk_cnt_r != 32'hFFFF_FFFF)) begin
      blk_cnt_r <= blk_cnt_r + 32'd1;
    end
  end

  assign blk_cnt = blk_cnt_r;
`else
  // No completed-block counter in this build
`endif

  assign in_ready   = in_ready_s;
  assign mode_err   = mode_err_s;
  assign busy       = (state_r != ST_IDLE);
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign core_start = core_start_r;
  assign core_enc   = core_enc_r;
  assign core_din   = core_din_r;

endmodule

// File: tb/tb_bcom_mode_engine.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bcom_mode_engine (BLOCK_W=128, CTR_W=32) with a stub
// core: core_dout = ~core_din, core_done three cycles after core_start.
// Expected values come from a block-level model of the five modes.
// -----------------------------------------------------------------------------
module tb_bcom_mode_engine;
  localparam int BW = 128;

  logic          Clk = 1'b0;
  logic          RstN = 1'b0;
  logic          clr = 1'b0;
  logic [2:0]    mode = 3'd0;
  logic          encrypt = 1'b0;
  logic          iv_load = 1'b0;
  logic [BW-1:0] iv = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          mode_err;
  logic          busy;
  logic          core_start;
  logic          core_enc;
  logic [BW-1:0] core_din;
  logic          core_done;
  logic [BW-1:0] core_dout;

  int n_chk = 0;
  int n_fail = 0;
  logic [BW-1:0] model_chain = '0;

  bcom_mode_engine #(.BLOCK_W(BW), .CTR_W(32)) dut (
    .Clk(Clk), .RstN(RstN), .clr(clr), .mode(mode), .encrypt(encrypt),
    .iv_load(iv_load), .iv(iv), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .mode_err(mode_err), .busy(busy),
    .core_start(core_start), .core_enc(core_enc), .core_din(core_din),
    .core_done(core_done), .core_dout(core_dout)
  );

  always #5 Clk = ~Clk;

  // Stub core, deliberately not reset so an in-flight result can arrive late
  logic [BW-1:0] stub_din = '0;
  int            stub_cnt = 0;
  always @(posedge Clk) begin
    if (core_start) begin
      stub_din <= core_din;
      stub_cnt <= 3;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign core_done = (stub_cnt == 1);
  assign core_dout = ~stub_din;

  task automatic chk(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Block-level mode model with the stub cipher E(v) = ~v folded in
  task automatic model(input logic [2:0] m, input logic e, input logic [BW-1:0] x,
                       input logic [BW-1:0] c, output logic [BW-1:0] din,
                       output logic en, output logic [BW-1:0] res,
                       output logic [BW-1:0] nc);
    case (m)
      3'd0: begin din = x; en = e; res = ~x; nc = c; end
      3'd1: begin
        if (e) begin din = x ^ c; en = 1'b1; res = ~(x ^ c); nc = res; end
        else   begin din = x; en = 1'b0; res = (~x) ^ c; nc = x; end
      end
      3'd2: begin din = c; en = 1'b1; res = (~c) ^ x; nc = ~c; end
      3'd3: begin din = c; en = 1'b1; res = (~c) ^ x; nc = {c[127:32], c[31:0] + 32'd1}; end
      default: begin din = c; en = 1'b1; res = (~c) ^ x; nc = e ? res : x; end
    endcase
  endtask

  task automatic load_iv(input logic [BW-1:0] v);
    iv = v;
    iv_load = 1'b1;
    #1 chk("iv_load_blocks_ready", BW'(in_ready), BW'(0));
    @(negedge Clk);
    iv_load = 1'b0;
    model_chain = v;
  endtask

  // One full block transaction, entered and left on a negedge
  task automatic run_block(input logic [2:0] m, input logic e, input logic [BW-1:0] x,
                           input int bp, output logic [BW-1:0] din_seen,
                           output logic [BW-1:0] res_seen);
    logic [BW-1:0] xd, xr, xc;
    logic xe;
    int n;
    model(m, e, x, model_chain, xd, xe, xr, xc);
    mode = m; encrypt = e; in_data = x; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin @(negedge Clk); n++; end
    chk("accept_ready", BW'(in_ready), BW'(1));
    @(negedge Clk);
    in_valid = 1'b0;
    // Input changes after accept must not disturb the block in flight
    mode = 3'($urandom_range(0, 4));
    encrypt = 1'($urandom);
    in_data = rnd128();
    din_seen = core_din;
    chk("core_start", BW'(core_start), BW'(1));
    chk("core_din", core_din, xd);
    chk("core_enc", BW'(core_enc), BW'(xe));
    n = 0;
    @(negedge Clk);
    chk("core_start_pulse", BW'(core_start), BW'(0));
    n = 1;
    while (!out_valid && n < 20) begin @(negedge Clk); n++; end
    chk("latency", BW'(n), BW'(4));
    chk("out_valid", BW'(out_valid), BW'(1));
    chk("out_data", out_data, xr);
    res_seen = out_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge Clk);
      chk("bp_out_valid", BW'(out_valid), BW'(1));
      chk("bp_out_stable", out_data, xr);
      chk("bp_in_ready", BW'(in_ready), BW'(0));
      chk("bp_no_start", BW'(core_start), BW'(0));
    end
    out_ready = 1'b1;
    @(negedge Clk);
    out_ready = 1'b0;
    chk("released", BW'(out_valid), BW'(0));
    chk("idle_after", BW'(busy), BW'(0));
    model_chain = xc;
  endtask

  initial begin
    logic [BW-1:0] d, r, r2, c1, v, x;
    logic [BW-1:0] pt [3];
    logic [BW-1:0] ct [3];

    repeat (3) @(negedge Clk);
    chk("rst_out_valid", BW'(out_valid), BW'(0));
    chk("rst_out_data", out_data, BW'(0));
    chk("rst_core_start", BW'(core_start), BW'(0));
    chk("rst_core_din", core_din, BW'(0));
    chk("rst_core_enc", BW'(core_enc), BW'(0));
    chk("rst_busy", BW'(busy), BW'(0));
    RstN = 1'b1;
    @(negedge Clk);
    chk("rst_in_ready", BW'(in_ready), BW'(1));

    // CBC encrypt then decrypt of the same two blocks
    c1 = ~BW'(1);
    load_iv(BW'(1));
    run_block(3'd1, 1'b1, BW'(0), 0, d, r);
    chk("cbc_e1_din", d, BW'(1));
    chk("cbc_e1_out", r, c1);
    run_block(3'd1, 1'b1, c1, 0, d, r2);
    chk("cbc_e2_din", d, BW'(0));
    chk("cbc_e2_out", r2, ~BW'(0));
    load_iv(BW'(1));
    run_block(3'd1, 1'b0, c1, 0, d, r);
    chk("cbc_d1_out", r, BW'(0));
    run_block(3'd1, 1'b0, r2, 0, d, r);
    chk("cbc_d2_out", r, c1);

    // CTR wrap of the low 32 bits only
    load_iv({{12{8'hAA}}, 32'hFFFF_FFFF});
    run_block(3'd3, 1'b1, rnd128(), 0, d, r);
    run_block(3'd3, 1'b1, rnd128(), 0, d, r);
    chk("ctr_wrap_din", d, {{12{8'hAA}}, 32'h0000_0000});

    // Backpressure: five cycles of out_ready low
    run_block(3'd0, 1'b1, rnd128(), 5, d, r);

    // iv_load wins over a simultaneous in_valid
    v = rnd128();
    x = rnd128();
    mode = 3'd2; encrypt = 1'b1; in_data = x; in_valid = 1'b1;
    iv = v; iv_load = 1'b1;
    #1 chk("simul_in_ready", BW'(in_ready), BW'(0));
    @(negedge Clk);
    iv_load = 1'b0;
    model_chain = v;
    chk("simul_no_accept", BW'(busy), BW'(0));
    run_block(3'd2, 1'b1, x, 0, d, r);
    chk("ofb_din_is_iv", d, v);

    // Reserved mode is rejected without any state change
    mode = 3'd6; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clk);
      chk("rsv_mode_err", BW'(mode_err), BW'(1));
      chk("rsv_in_ready", BW'(in_ready), BW'(0));
      chk("rsv_busy", BW'(busy), BW'(0));
    end
    in_valid = 1'b0;
    mode = 3'd0;

    // CFB round trip over three blocks
    v = rnd128();
    load_iv(v);
    for (int i = 0; i < 3; i++) begin
      pt[i] = rnd128();
      run_block(3'd4, 1'b1, pt[i], 0, d, ct[i]);
    end
    load_iv(v);
    for (int i = 0; i < 3; i++) begin
      run_block(3'd4, 1'b0, ct[i], 0, d, r);
      chk("cfb_roundtrip", r, pt[i]);
    end

    // Randomised mix of modes, directions, IVs and backpressure
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) == 0) load_iv(rnd128());
      run_block(3'($urandom_range(0, 4)), 1'($urandom), rnd128(),
                int'($urandom_range(0, 2)), d, r);
    end

    // Asynchronous reset while the core is in flight
    mode = 3'd0; encrypt = 1'b1; in_data = rnd128(); in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    @(negedge Clk);
    chk("wait_busy", BW'(busy), BW'(1));
    RstN = 1'b0;
    #1;
    chk("arst_out_valid", BW'(out_valid), BW'(0));
    chk("arst_in_ready", BW'(in_ready), BW'(1));
    chk("arst_core_start", BW'(core_start), BW'(0));
    chk("arst_busy", BW'(busy), BW'(0));
    @(negedge Clk);
    RstN = 1'b1;
    model_chain = '0;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("late_done_ignored", BW'(out_valid), BW'(0));
    end

    // Soft clear while the core is in flight, chain must return to zero
    load_iv(rnd128());
    in_data = rnd128(); in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    @(negedge Clk);
    clr = 1'b1;
    @(negedge Clk);
    clr = 1'b0;
    model_chain = '0;
    chk("clr_busy", BW'(busy), BW'(0));
    chk("clr_out_data", out_data, BW'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("clr_late_done", BW'(out_valid), BW'(0));
    end
    run_block(3'd2, 1'b1, rnd128(), 1, d, r);
    chk("clr_chain_zero", d, BW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
